// File: rtl/tmds_frame_controller.sv
// Purpose: sequences the three TMDS channels (raster timing, DE, control buses, pixel fetch) in 10-cycle character slots.
// Latency: outputs are registered and move only on the phase 9->0 edge; first character one cycle after enable.
// Backpressure: none; the source must answer each pixelReq within the remaining 9 cycles of the requesting slot.
module tmds_frame_controller #(
    parameter int   H_ACTIVE  = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_ACTIVE  = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic        serialClk,
    input  logic        resetN,
    input  logic        enable,
    input  logic [23:0] pixelIn,
    output logic        pixelReq,
    output logic [10:0] reqX,
    output logic [9:0]  reqY,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        de,
    output logic [1:0]  ctl0,
    output logic [1:0]  ctl1,
    output logic [1:0]  ctl2,
    output logic [3:0]  charPhase,
    output logic        frameStart
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sync windows are stored as inclusive last indices so a zero back porch cannot overflow the counter width.
    localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_LST = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_ACT_END  = 10'(V_ACTIVE);
    localparam logic [9:0]  V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  V_SYNC_LST = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [3:0]  PHASE_LAST = 4'd9;
    localparam logic [1:0]  CTL0_IDLE  = {~VSYNC_POL, ~HSYNC_POL};

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  phase_q, phase_d;
    logic [10:0] h_q, h_d, h_nxt;
    logic [9:0]  v_q, v_d, v_nxt;
    logic        de_q, de_d;
    logic [1:0]  ctl0_q, ctl0_d;
    logic [23:0] pix_q, pix_d;
    logic        frame_start_q, frame_start_d;
    logic        frame_end;

    function automatic logic is_active(input logic [10:0] h, input logic [9:0] v);
        return (h < H_ACT_END) && (v < V_ACT_END);
    endfunction

    function automatic logic [1:0] ctl0_at(input logic [10:0] h, input logic [9:0] v);
        logic hs;
        logic vs;
        hs = (h >= H_SYNC_BEG) && (h <= H_SYNC_LST);
        vs = (v >= V_SYNC_BEG) && (v <= V_SYNC_LST);
        return {vs ? VSYNC_POL : ~VSYNC_POL, hs ? HSYNC_POL : ~HSYNC_POL};
    endfunction

    // Coordinates of the character slot that follows the current one (wraps line and frame).
    always_comb begin
        h_nxt = h_q + 11'd1;
        v_nxt = v_q;
        if (h_q == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v_q == V_LAST) ? '0 : v_q + 10'd1;
        end
    end

    assign frame_end = (h_q == H_LAST) && (v_q == V_LAST) && (phase_q == PHASE_LAST);

    // Next-state logic: slot phase, raster counters and the encoder-facing outputs for the coming slot.
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        h_d           = h_q;
        v_d           = v_q;
        de_d          = de_q;
        ctl0_d        = ctl0_q;
        pix_d         = pix_q;
        frame_start_d = frame_start_q;
        case (state_q)
            ST_IDLE: begin
                phase_d       = '0;
                h_d           = '0;
                v_d           = '0;
                de_d          = 1'b0;
                ctl0_d        = CTL0_IDLE;
                pix_d         = '0;
                frame_start_d = 1'b0;
                if (enable) begin
                    // Nothing could have been fetched for (0,0), so the first character of this frame is black.
                    state_d       = ST_RUN;
                    de_d          = is_active('0, '0);
                    ctl0_d        = ctl0_at('0, '0);
                    frame_start_d = 1'b1;
                end
            end
            default: begin
                if (phase_q == PHASE_LAST) begin
                    phase_d = '0;
                    if (frame_end && !enable) begin
                        state_d       = ST_IDLE;
                        h_d           = '0;
                        v_d           = '0;
                        de_d          = 1'b0;
                        ctl0_d        = CTL0_IDLE;
                        pix_d         = '0;
                        frame_start_d = 1'b0;
                    end else begin
                        h_d           = h_nxt;
                        v_d           = v_nxt;
                        de_d          = is_active(h_nxt, v_nxt);
                        ctl0_d        = ctl0_at(h_nxt, v_nxt);
                        pix_d         = is_active(h_nxt, v_nxt) ? pixelIn : '0;
                        frame_start_d = (h_nxt == '0) && (v_nxt == '0);
                    end
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
        endcase
    end

    // State and output registers; reset forces the idle levels without waiting for a clock.
    always_ff @(posedge serialClk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= ST_IDLE;
            phase_q       <= '0;
            h_q           <= '0;
            v_q           <= '0;
            de_q          <= 1'b0;
            ctl0_q        <= CTL0_IDLE;
            pix_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            h_q           <= h_d;
            v_q           <= v_d;
            de_q          <= de_d;
            ctl0_q        <= ctl0_d;
            pix_q         <= pix_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Fetch for the next slot is issued at phase 0 so the source has the rest of the slot to respond.
    assign pixelReq   = (state_q == ST_RUN) && (phase_q == '0) && is_active(h_nxt, v_nxt);
    assign reqX       = pixelReq ? h_nxt : '0;
    assign reqY       = pixelReq ? v_nxt : '0;
    assign red        = pix_q[23:16];
    assign green      = pix_q[15:8];
    assign blue       = pix_q[7:0];
    assign de         = de_q;
    assign ctl0       = ctl0_q;
    assign ctl1       = 2'b00;
    assign ctl2       = 2'b00;
    assign charPhase  = phase_q;
    assign frameStart = frame_start_q;

endmodule

// File: tb/tb_tmds_frame_controller.sv
// Bench for tmds_frame_controller on an 8x6-slot raster, checked cycle by cycle against a time-based model.
// The model derives slot, phase and raster position purely from cycles elapsed since RUN entry.
// Source either echoes requested coordinates or drives random pixels every cycle.
module tb_tmds_frame_controller;

    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int SLOTS = HT * VT;
    localparam int FRAME_CYC = SLOTS * 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [23:0] pixel_in;
    logic        pixel_req;
    logic [10:0] req_x;
    logic [9:0]  req_y;
    logic [7:0]  red, green, blue;
    logic        de;
    logic [1:0]  ctl0, ctl1, ctl2;
    logic [3:0]  char_phase;
    logic        frame_start;

    int n_checks = 0;
    int n_fail   = 0;
    bit src_echo = 1'b0;

    // Reference model state: running flag, cycles since RUN entry, and the pixel expected on the outputs.
    bit          m_run = 1'b0;
    int          m_t   = 0;
    logic [23:0] m_rgb = '0;

    tmds_frame_controller #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut (
        .serialClk (clk),
        .resetN    (rst_n),
        .enable    (enable),
        .pixelIn   (pixel_in),
        .pixelReq  (pixel_req),
        .reqX      (req_x),
        .reqY      (req_y),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .de        (de),
        .ctl0      (ctl0),
        .ctl1      (ctl1),
        .ctl2      (ctl2),
        .charPhase (char_phase),
        .frameStart(frame_start)
    );

    always #5 clk = ~clk;

    function automatic bit slot_active(input int s);
        return ((s % HT) < HA) && ((s / HT) < VA);
    endfunction

    // Model: a frame is SLOTS slots of 10 cycles; the pixel shown in a slot is whatever the source
    // presented at the end of the preceding slot; enable only matters at the very last cycle of a frame.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run <= 1'b0;
            m_t   <= 0;
            m_rgb <= '0;
        end else if (!m_run) begin
            if (enable) begin
                m_run <= 1'b1;
                m_t   <= 0;
                m_rgb <= '0;
            end
        end else begin
            if ((m_t % 10) == 9) begin
                m_rgb <= slot_active(((m_t / 10) + 1) % SLOTS) ? pixel_in : '0;
                if (((m_t / 10) % SLOTS) == SLOTS - 1 && !enable) m_run <= 1'b0;
            end
            m_t <= m_t + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_cycle();
        int ph, fs, h, v, ns;
        logic [1:0] exp_ctl0;
        if (!m_run) begin
            check_eq("idle_de", 32'(de), 32'(0));
            check_eq("idle_ctl0", 32'(ctl0), 32'(2'b11));
            check_eq("idle_rgb", 32'({red, green, blue}), 32'(0));
            check_eq("idle_req", 32'(pixel_req), 32'(0));
            check_eq("idle_phase", 32'(char_phase), 32'(0));
            check_eq("idle_fs", 32'(frame_start), 32'(0));
        end else begin
            ph = m_t % 10;
            fs = (m_t / 10) % SLOTS;
            h  = fs % HT;
            v  = fs / HT;
            ns = (fs + 1) % SLOTS;
            exp_ctl0 = 2'b11;
            if (v >= VA + VF && v < VA + VF + VS) exp_ctl0[1] = 1'b0;
            if (h >= HA + HF && h < HA + HF + HS) exp_ctl0[0] = 1'b0;
            check_eq("run_phase", 32'(char_phase), 32'(ph));
            check_eq("run_de", 32'(de), 32'(slot_active(fs)));
            check_eq("run_ctl0", 32'(ctl0), 32'(exp_ctl0));
            check_eq("run_fs", 32'(frame_start), 32'(fs == 0));
            check_eq("run_rgb", 32'({red, green, blue}), 32'(m_rgb));
            check_eq("run_req", 32'(pixel_req), 32'(ph == 0 && slot_active(ns)));
            if (ph == 0 && slot_active(ns)) begin
                check_eq("run_req_x", 32'(req_x), 32'(ns % HT));
                check_eq("run_req_y", 32'(req_y), 32'(ns / HT));
            end
        end
        check_eq("ctl12", 32'({ctl1, ctl2}), 32'(0));
    endtask

    // One clock: check outputs 1 time unit after the edge, then let the source respond.
    task automatic tick();
        @(posedge clk);
        #1;
        check_cycle();
        if (src_echo) begin
            if (pixel_req) pixel_in = {req_y[7:0], req_x[7:0], 8'hA5};
        end else begin
            pixel_in = 24'($urandom);
        end
    endtask

    task automatic run_frame(input bit echo);
        int de_c = 0;
        int req_c = 0;
        int fs_c = 0;
        int hs_c = 0;
        int vs_c = 0;
        int chg = 0;
        int s;
        logic [26:0] prev = '0;
        logic [26:0] cur;
        src_echo = echo;
        for (int c = 0; c < FRAME_CYC; c++) begin
            tick();
            cur = {de, ctl0, red, green, blue};
            if (c > 0 && (m_t % 10) != 0 && cur != prev) chg++;
            prev = cur;
            if (de) de_c++;
            if (pixel_req) req_c++;
            if (frame_start) fs_c++;
            if (!ctl0[0]) hs_c++;
            if (!ctl0[1]) vs_c++;
            s = (m_t / 10) % SLOTS;
            if (echo && m_t >= 10 && (m_t % 10) == 5 && slot_active(s)) begin
                check_eq("echo_red", 32'(red), 32'(s / HT));
                check_eq("echo_green", 32'(green), 32'(s % HT));
                check_eq("echo_blue", 32'(blue), 32'hA5);
            end
        end
        check_eq("frame_de_cycles", 32'(de_c), 32'(HA * VA * 10));
        check_eq("frame_req_count", 32'(req_c), 32'(HA * VA));
        check_eq("frame_fs_cycles", 32'(fs_c), 32'(10));
        check_eq("frame_hsync_cycles", 32'(hs_c), 32'(HS * VT * 10));
        check_eq("frame_vsync_cycles", 32'(vs_c), 32'(VS * HT * 10));
        check_eq("frame_midslot_changes", 32'(chg), 32'(0));
    endtask

    initial begin
        int de_c;
        rst_n    = 1'b0;
        enable   = 1'b0;
        pixel_in = '0;

        // Reset held: inputs toggle, outputs must stay at idle values.
        for (int i = 0; i < 20; i++) begin
            tick();
            enable = 1'($urandom);
        end
        enable = 1'b0;
        rst_n  = 1'b1;
        for (int i = 0; i < 5; i++) tick();

        // Two echo frames, then one random-pixel frame, all continuous.
        enable = 1'b1;
        run_frame(1'b1);
        run_frame(1'b1);
        run_frame(1'b0);

        // Graceful stop: drop enable inside slot (2,1) of the fourth frame.
        for (int i = 0; i < 101; i++) tick();
        check_eq("drop_point", 32'(((m_t / 10) % SLOTS)), 32'(HT + 2));
        enable = 1'b0;
        de_c = 0;
        for (int i = 0; i < FRAME_CYC - 101; i++) begin
            tick();
            if (de) de_c++;
        end
        check_eq("stop_de_after_drop", 32'(de_c), 32'(59));
        check_eq("stop_last_phase", 32'(char_phase), 32'(9));
        tick();
        check_eq("stop_idle_de", 32'(de), 32'(0));
        check_eq("stop_idle_phase", 32'(char_phase), 32'(0));
        tick();
        tick();
        enable = 1'b1;
        tick();
        check_eq("restart_fs", 32'(frame_start), 32'(1));
        check_eq("restart_de", 32'(de), 32'(1));

        // Async reset at phase 5 of slot (3,0).
        for (int i = 0; i < 35; i++) tick();
        check_eq("pre_reset_de", 32'(de), 32'(1));
        check_eq("pre_reset_phase", 32'(char_phase), 32'(5));
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("areset_de", 32'(de), 32'(0));
        check_eq("areset_ctl0", 32'(ctl0), 32'(2'b11));
        check_eq("areset_rgb", 32'({red, green, blue}), 32'(0));
        check_eq("areset_phase", 32'(char_phase), 32'(0));
        check_eq("areset_req", 32'(pixel_req), 32'(0));
        check_cycle();
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b1;
        tick();
        check_eq("post_reset_fs", 32'(frame_start), 32'(1));
        check_eq("post_reset_phase", 32'(char_phase), 32'(0));
        for (int i = 0; i < FRAME_CYC - 1; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/tmds_frame_controller.md
# tmds_frame_controller

Sequences the three TMDS encoder/serializer channels of the HDMI transmitter. Runs entirely in the serial clock domain and divides it into 10-cycle character slots. Generates horizontal/vertical raster timing, DE, and the per-channel control buses, and fetches pixels from an upstream source through a request/sample handshake. It also holds every encoder input stable for a whole character slot, because the encoders sample their inputs combinationally.

## Interface

**Parameters**
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (characters)
- H_SYNC, 96, hsync width (characters)
- H_BP, 48, horizontal back porch (characters)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, hsync asserted level
- VSYNC_POL, 0, vsync asserted level

**Ports**
- serialClk, in, 1, TMDS serial clock (10x pixel clock)
- resetN, in, 1, asynchronous active-low reset
- enable, in, 1, request raster output
- pixelIn, in, 24, {R,G,B} from source
- pixelReq, out, 1, one-cycle fetch pulse
- reqX, out, 11, column of requested pixel
- reqY, out, 10, row of requested pixel
- red/green/blue, out, 8 each, encoder pixel components
- de, out, 1, shared Display Enable
- ctl0/ctl1/ctl2, out, 2 each, control bus for channels 0/1/2
- charPhase, out, 4, slot phase 0..9
- frameStart, out, 1, pulse at h=0,v=0

## Operation

- **Phase counter:** counts 0..9 in RUN, wraps 9→0. It is 0 in IDLE and after reset.
- **Raster counters:**
  - hCount runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - vCount runs 0..V_TOTAL-1.
  - hCount advances on each 9→0 phase edge.
  - vCount advances when hCount wraps.
  - Both wrap to 0 together at the end of the frame.
- **Region order:** active, front porch, sync, back porch.
- **de** = (hCount<H_ACTIVE)&&(vCount<V_ACTIVE).
- **Sync:**
  - hsync is asserted for hCount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync is asserted for vCount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), over whole lines.
  - Asserted level = *_POL; deasserted level = ~*_POL.
- **Control buses:** ctl0 = {vsync, hsync}; ctl1 = ctl2 = 2'b00. Control bits are driven continuously; the encoders ignore them while de=1.
- **Pixel output:** red/green/blue = pixelIn sampled for an active character, otherwise 0.
- **State machine:**
  - IDLE:
    - de=0, ctl0={~VSYNC_POL,~HSYNC_POL}, pixel outputs 0, phase held at 0.
    - enable=1 → RUN with h=v=0, phase=0, and a frameStart pulse.
  - RUN:
    - enable sampled only at the end of the frame (h=H_TOTAL-1, v=V_TOTAL-1, phase=9).
    - If enable=0 there → IDLE. A deassertion mid-frame completes the frame.
- **Reset:** asynchronous and effective at any point mid-frame. Returns to IDLE with all outputs at their IDLE values, counters 0, pixelReq=0, frameStart=0.
- **Width rules:** counters unsigned. H_TOTAL ≤ 2048 and V_TOTAL ≤ 1024 are required.

## Timing

- **Output update edge:** de, ctl*, red/green/blue and frameStart are registered and change only on the edge where phase goes 9→0 (and on IDLE→RUN entry). They are stable for all 10 cycles of a slot.
- **Fetch:** pixelReq pulses for one cycle at phase 0 of the slot preceding each active character. reqX/reqY give that character's coordinates.
  - The first request of a line comes in the slot hCount=H_TOTAL-1 of the previous line.
  - For the first line of a frame, it comes in the last slot of the previous frame, or at IDLE→RUN entry for the very first frame.
  - A first frame entered from IDLE shows pixel (0,0) as 0.
- **Sampling:** pixelIn is sampled on the phase 9→0 edge of the requesting slot. The source has 9 cycles of latency budget.
- **Alignment:** serializers load on their own count-9 cycle; reset shares resetN so the slots coincide.
- **Latency:** enable high to first character = 1 cycle. frameStart is high for exactly 10 cycles, during slot (0,0).

## Test plan

Small raster for all scenarios: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1 (8×6, 48 slots = 480 cycles/frame).

1. **Reset values:** hold resetN=0, toggle enable and pixelIn → de=0, ctl0=2'b11, pixel outputs 0, pixelReq=0, charPhase=0.
2. **Raster shape:** enable=1 for 2 frames →
   - de high exactly 12 slots per frame (h0-3 on v0-2);
   - ctl0[0] low only at h5-6;
   - ctl0[1] low for all 8 slots of v4;
   - frameStart every 480 cycles.
3. **Pixel pipeline:** source returns pixelIn = {reqY,reqX,8'hA5} → at slot (x,y), red=y, green=x, blue=8'hA5; pixelReq count = 12 per frame.
4. **Stability:** with pixelIn changing every cycle → red/green/blue/de/ctl* change only on phase 9→0 edges.
5. **Graceful stop:** drop enable at slot (2,1) → frame completes through (7,5), then IDLE. Reassert 3 cycles later → frameStart 1 cycle later.
6. **Async reset mid-frame:** resetN low at phase 5 of slot (3,0) → outputs go to IDLE values immediately, without a clock edge. After release with enable=1 → restart at (0,0).
